// File: rtl/floo_mcast_enum.sv
// Multicast destination enumerator: expands one masked destination into every
// covered unicast (x, y), one per cycle, with the payload copied on each beat.
module floo_mcast_enum #(
  parameter int unsigned XWidth    = 4,
  parameter int unsigned YWidth    = 4,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [XWidth-1:0]    dst_x_i,
  input  logic [YWidth-1:0]    dst_y_i,
  input  logic [XWidth-1:0]    mask_x_i,
  input  logic [YWidth-1:0]    mask_y_i,
  input  logic                 dec_error_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XWidth-1:0]    out_x_o,
  output logic [YWidth-1:0]    out_y_o,
  output logic                 out_last_o,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 err_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q;
  logic [XWidth-1:0]    base_x_q, mask_x_q, sub_x_q, next_sub_x;
  logic [YWidth-1:0]    base_y_q, mask_y_q, sub_y_q, next_sub_y;
  logic [DataWidth-1:0] data_q;
  logic                 err_q;
  logic                 busy, x_done, accept, out_hs;

  assign busy   = (state_q == BUSY);
  assign x_done = (sub_x_q == mask_x_q);

  // Subset enumeration: force unmasked bits to one so the carry ripples
  // straight through them, then keep only the masked bits.
  assign next_sub_x = ((sub_x_q | ~mask_x_q) + XWidth'(1)) & mask_x_q;
  assign next_sub_y = ((sub_y_q | ~mask_y_q) + YWidth'(1)) & mask_y_q;

  assign out_valid_o = busy;
  assign out_x_o     = base_x_q | sub_x_q;
  assign out_y_o     = base_y_q | sub_y_q;
  assign out_last_o  = busy && x_done && (sub_y_q == mask_y_q);
  assign out_data_o  = data_q;
  assign err_o       = err_q;

  assign out_hs     = out_valid_o && out_ready_i;
  assign in_ready_o = !busy || (out_hs && out_last_o);
  assign accept     = in_valid_i && in_ready_o;

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      base_x_q <= '0;
      base_y_q <= '0;
      mask_x_q <= '0;
      mask_y_q <= '0;
      sub_x_q  <= '0;
      sub_y_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        if (dec_error_i) begin
          state_q <= IDLE;
          err_q   <= 1'b1;
        end else begin
          state_q  <= BUSY;
          base_x_q <= dst_x_i & ~mask_x_i;
          base_y_q <= dst_y_i & ~mask_y_i;
          mask_x_q <= mask_x_i;
          mask_y_q <= mask_y_i;
          sub_x_q  <= '0;
          sub_y_q  <= '0;
          data_q   <= data_i;
        end
      end else if (out_hs) begin
        if (out_last_o) begin
          state_q <= IDLE;
        end else if (x_done) begin
          sub_x_q <= '0;
          sub_y_q <= next_sub_y;
        end else begin
          sub_x_q <= next_sub_x;
        end
      end
    end
  end

endmodule

// File: tb/tb_floo_mcast_enum.sv
// Bench for floo_mcast_enum: directed scenarios plus random traffic, scored
// against a destination list built by brute-force search over the grid.
module tb_floo_mcast_enum;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  dst_x_i, dst_y_i, mask_x_i, mask_y_i;
  logic        dec_error_i;
  logic [31:0] data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  out_x_o, out_y_o;
  logic        out_last_o;
  logic [31:0] out_data_o;
  logic        err_o;

  floo_mcast_enum #(.XWidth(4), .YWidth(4), .DataWidth(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .dst_x_i     (dst_x_i),
    .dst_y_i     (dst_y_i),
    .mask_x_i    (mask_x_i),
    .mask_y_i    (mask_y_i),
    .dec_error_i (dec_error_i),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_x_o     (out_x_o),
    .out_y_o     (out_y_o),
    .out_last_o  (out_last_o),
    .out_data_o  (out_data_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  x;
    logic [3:0]  y;
    logic        last;
    logic [31:0] data;
  } dest_t;

  dest_t exp_q[$];
  logic  err_pend;
  logic  accepted;
  int    rdy_mode;   // 0: always ready, 1: toggle, 2: random
  int    cyc;
  int    passed = 0;
  int    total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: scan the whole grid in row-major order (y outer, x inner),
  // keeping every point that agrees with the base on the unmasked bits.
  task automatic push_dests(input logic [3:0] dx, input logic [3:0] dy,
                            input logic [3:0] mx, input logic [3:0] my,
                            input logic [31:0] d);
    int cnt, idx;
    logic [3:0] xv, yv;
    dest_t e;
    cnt = 1 << ($countones(mx) + $countones(my));
    idx = 0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        xv = 4'(x);
        yv = 4'(y);
        if (((xv & ~mx) == (dx & ~mx)) && ((yv & ~my) == (dy & ~my))) begin
          e.x = xv; e.y = yv; e.data = d;
          e.last = (idx == cnt - 1);
          exp_q.push_back(e);
          idx++;
        end
      end
    end
  endtask

  // One clock cycle: entered just after a rising edge with inputs applied.
  task automatic tick();
    logic model_rdy;
    dest_t h;
    case (rdy_mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = cyc[0];
      default: out_ready_i = 1'($urandom);
    endcase
    #1;
    model_rdy = (exp_q.size() == 0) || (out_ready_i && exp_q.size() == 1);
    chk("in_ready", 64'(in_ready_o), 64'(model_rdy));
    chk("out_valid", 64'(out_valid_o), 64'(exp_q.size() != 0));
    chk("err", 64'(err_o), 64'(err_pend));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk("out_x", 64'(out_x_o), 64'(h.x));
      chk("out_y", 64'(out_y_o), 64'(h.y));
      chk("out_last", 64'(out_last_o), 64'(h.last));
      chk("out_data", 64'(out_data_o), 64'(h.data));
      if (out_ready_i) void'(exp_q.pop_front());
    end
    err_pend = 1'b0;
    accepted = in_valid_i && model_rdy;
    if (accepted) begin
      if (dec_error_i) err_pend = 1'b1;
      else push_dests(dst_x_i, dst_y_i, mask_x_i, mask_y_i, data_i);
    end
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [3:0] dx, input logic [3:0] dy,
                      input logic [3:0] mx, input logic [3:0] my,
                      input logic e, input logic [31:0] d);
    dst_x_i = dx; dst_y_i = dy; mask_x_i = mx; mask_y_i = my;
    dec_error_i = e; data_i = d; in_valid_i = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 2000 && !accepted; i++) tick();
    if (!accepted) chk("accept_timeout", 64'(accepted), 64'(1));
    in_valid_i = 1'b0;
    dst_x_i = 'x; dst_y_i = 'x; data_i = 'x;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && (exp_q.size() != 0 || err_pend); i++) tick();
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    tick();
  endtask

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    dst_x_i = '0; dst_y_i = '0; mask_x_i = '0; mask_y_i = '0;
    dec_error_i = 1'b0; data_i = '0;
    err_pend = 1'b0; rdy_mode = 0; cyc = 0;
    #12;
    chk("rst_out_valid", 64'(out_valid_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    chk("rst_last", 64'(out_last_o), 64'(0));
    chk("rst_x", 64'(out_x_o), 64'(0));
    chk("rst_y", 64'(out_y_o), 64'(0));
    chk("rst_data", 64'(out_data_o), 64'(0));
    chk("rst_in_ready", 64'(in_ready_o), 64'(1));
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single destination, then a sparse X mask, then a two-axis mask.
    send(4'd5, 4'd9, 4'h0, 4'h0, 1'b0, 32'hA5A5_0001);
    drain();
    send(4'd2, 4'd3, 4'b0101, 4'h0, 1'b0, 32'h0000_0002);
    drain();
    send(4'd8, 4'd4, 4'b0001, 4'b0010, 1'b0, 32'h0000_0003);
    drain();

    // Same request with a stalling consumer.
    rdy_mode = 1;
    send(4'd8, 4'd4, 4'b0001, 4'b0010, 1'b0, 32'h0000_0004);
    drain();
    rdy_mode = 0;

    // Back-to-back: the second request waits for the first's last beat.
    send(4'd2, 4'd3, 4'b0101, 4'h0, 1'b0, 32'h0000_0005);
    send(4'd8, 4'd4, 4'b0001, 4'b0010, 1'b0, 32'h0000_0006);
    drain();

    // Decode error is dropped with a single err pulse.
    send(4'd1, 4'd1, 4'h3, 4'h0, 1'b1, 32'h0000_0007);
    drain();

    // Full X range wraps and ends at all-ones.
    send(4'd0, 4'd7, 4'hF, 4'h0, 1'b0, 32'h0000_0008);
    drain();

    // Asynchronous reset during the second of four outputs.
    send(4'd8, 4'd4, 4'b0001, 4'b0010, 1'b0, 32'h0000_0009);
    tick();
    chk("pre_rst_x", 64'(out_x_o), 64'(9));
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid_o), 64'(0));
    chk("mid_rst_ready", 64'(in_ready_o), 64'(1));
    chk("mid_rst_err", 64'(err_o), 64'(0));
    exp_q.delete();
    err_pend = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    tick();
    tick();

    // Random traffic with random back-pressure and occasional decode errors.
    rdy_mode = 2;
    for (int n = 0; n < 60; n++) begin
      send(4'($urandom), 4'($urandom), 4'($urandom & $urandom),
           4'($urandom & $urandom), ($urandom_range(0, 7) == 0), $urandom);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/floo_mcast_enum.md
# floo_mcast_enum

Multicast destination enumerator that sits directly downstream of the multicast mask decoder. It takes one multicast request per handshake: a base destination coordinate, the X/Y don't-care masks from the decoder, and its decode-error flag. It then emits, one per cycle under valid/ready back-pressure, every unicast (x, y) coordinate covered by the masked destination. The payload is replicated unchanged on each emitted destination, so the output feeds unicast-only injection or route-table logic.

## Interface
- XWidth, 4, width of X coordinate and X mask
- YWidth, 4, width of Y coordinate and Y mask
- DataWidth, 32, opaque payload width carried alongside each destination

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request accepted when in_valid_i && in_ready_o
- dst_x_i  in  XWidth  base X coordinate
- dst_y_i  in  YWidth  base Y coordinate
- mask_x_i  in  XWidth  X don't-care bits (1 = enumerate this bit)
- mask_y_i  in  YWidth  Y don't-care bits
- dec_error_i  in  1  mask decode failed for this request
- data_i  in  DataWidth  payload
- out_valid_o  out  1  destination valid
- out_ready_i  in  1  destination consumed when out_valid_o && out_ready_i
- out_x_o  out  XWidth  emitted X coordinate
- out_y_o  out  YWidth  emitted Y coordinate
- out_last_o  out  1  final destination of current request
- out_data_o  out  DataWidth  payload copy
- err_o  out  1  one-cycle pulse: a request with dec_error_i was dropped

## Operation
- Destination set: all (x, y) with (x & ~mask_x) == (dst_x & ~mask_x) and (y & ~mask_y) == (dst_y & ~mask_y).
- Set size is 2^(popcount(mask_x)+popcount(mask_y)); all-zero masks give exactly one destination.
- Registers: base_x/base_y (the destination with masked bits cleared), mask_x/mask_y, sub_x/sub_y (subset counters), data, state.
- Emitted coordinates: out_x_o = base_x | sub_x; out_y_o = base_y | sub_y.
- Subset step, modulo 2^width: next_sub = ((sub | ~mask) + 1) & mask.
- Order: X varies fastest, ascending by numeric value of sub_x. When sub_x == mask_x, sub_x wraps to 0 and sub_y steps.
- out_last_o = (sub_x == mask_x) && (sub_y == mask_y).
- States: IDLE, BUSY.
  - IDLE: out_valid_o = 0, in_ready_o = 1.
  - IDLE, accept with dec_error_i = 0: load the registers, set sub_x = sub_y = 0, go to BUSY.
  - IDLE, accept with dec_error_i = 1: stay in IDLE and pulse err_o on the next cycle. No output is produced.
  - BUSY: out_valid_o = 1. On a non-last output handshake, advance the subset counters.
  - BUSY, last output handshake, no new request: go to IDLE.
- in_ready_o = (state == IDLE) || (out_valid_o && out_ready_i && out_last_o), so back-to-back requests run without a bubble.
- Simultaneous last output handshake and new accept: load the new request and stay in BUSY. If the new request has a decode error, go to IDLE and pulse err_o.
- Output stability: while out_valid_o && !out_ready_i, all out_* signals hold stable.
- Input ports are sampled only on an accept.

## Timing
- Reset values: out_valid_o = 0, err_o = 0, out_last_o = 0, out_x_o = 0, out_y_o = 0, out_data_o = 0, in_ready_o = 1 (IDLE). All registers clear.
- Latency: a request accepted at edge N gives its first destination valid after edge N (registered outputs, no combinational in-to-out path).
- Throughput: one destination per cycle with out_ready_i held high. N destinations occupy exactly N BUSY cycles.
- err_o is asserted for exactly the one cycle following the erroneous accept.
- in_ready_o depends combinationally on out_ready_i, only in the last-beat case.
- Reset mid-burst: return to IDLE immediately (asynchronous). Remaining destinations are discarded, out_valid_o drops to 0, and no err_o is raised.
- Wrap-around: the subset increment is truncated to XWidth/YWidth bits. Mask all-ones enumerates the full 2^width range, ending at all-ones.

## Test plan
- mask_x = mask_y = 0, dst = (5, 9), out_ready_i = 1 -> one output (5, 9) with last = 1, one cycle after accept; in_ready_o = 1 throughout.
- dst = (2, 3), mask_x = 4'b0101, mask_y = 0 -> x = 2, 3, 6, 7 at y = 3 on consecutive cycles; last only on x = 7.
- dst = (8, 4), mask_x = 4'b0001, mask_y = 4'b0010 -> outputs (8,4), (9,4), (8,6), (9,6); last on (9,6).
- Same as the previous scenario with out_ready_i toggling every other cycle -> identical sequence; outputs stable while stalled; no duplicated or skipped destinations.
- Two requests back-to-back, the second presented during the first's last beat -> second accepted on that beat; its first output on the next cycle with no bubble.
- dec_error_i = 1 on accept -> no out_valid_o, err_o high for exactly one cycle.
- Separately, assert rst_ni low during the 2nd of 4 outputs -> out_valid_o = 0 immediately; after release, IDLE with in_ready_o = 1.
